// File: rtl/dmux16_stream.sv
// ---------------------------------------------------------------------------
// dmux16_stream
//
// Registered 1-to-2 stream demultiplexer. Each word accepted on the input
// stream goes into a one-entry output slot. in_sel=0 selects slot A and
// in_sel=1 selects slot B. Each output slot has its own valid/ready
// handshake. A slot can be refilled in the same cycle that it drains, so
// each output can carry one word per cycle.
//
// Optional feature (macro DMUX16_COUNT_EN):
//   When the macro is defined, two extra outputs a_count/b_count are
//   present. Each is a 16-bit wrapping count of output handshakes on its
//   slot. When the macro is undefined, these ports do not exist.
//
// Ports:
//   clk               sole clock, rising edge
//   rst               asynchronous active-high reset; clears all state
//   in_data[WIDTH]    input word
//   in_sel            destination select: 0 -> slot A, 1 -> slot B
//   in_valid          producer offers in_data/in_sel
//   in_ready          block accepts this cycle (combinational)
//   a_data/a_valid    slot A contents and full flag
//   a_ready           consumer A takes the word
//   b_data/b_valid    slot B contents and full flag
//   b_ready           consumer B takes the word
//   a_count/b_count   16-bit handshake counters (DMUX16_COUNT_EN only)
// ---------------------------------------------------------------------------
module dmux16_stream #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DMUX16_COUNT_EN
  ,
  output logic [15:0]      a_count,
  output logic [15:0]      b_count
`endif
);

  // Index 0 is slot A and index 1 is slot B.
  logic             full_reg  [2];
  logic [WIDTH-1:0] data_reg  [2];
  logic [1:0]       out_ready;
  logic [1:0]       target;
  logic [1:0]       fill;
  logic [1:0]       drain;

  assign out_ready = {b_ready, a_ready};
  assign target    = {in_sel, ~in_sel};

  // in_ready depends only on the selected slot. A stalled slot therefore
  // never blocks words that are addressed to the other slot.
  assign in_ready = in_sel ? (!full_reg[1] || b_ready)
                           : (!full_reg[0] || a_ready);

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign fill[gi]  = in_valid && in_ready && target[gi];
    assign drain[gi] = full_reg[gi] && out_ready[gi];

    // A fill wins over a drain. The slot stays full and takes the new
    // word in place. A drain on its own leaves data unchanged.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full_reg[gi] <= 1'b0;
        data_reg[gi] <= '0;
      end else if (fill[gi]) begin
        full_reg[gi] <= 1'b1;
        data_reg[gi] <= in_data;
      end else if (drain[gi]) begin
        full_reg[gi] <= 1'b0;
      end
    end
  end

  assign a_valid = full_reg[0];
  assign a_data  = data_reg[0];
  assign b_valid = full_reg[1];
  assign b_data  = data_reg[1];

`ifdef DMUX16_COUNT_EN
  logic [15:0] count_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_count
    // The counter wraps naturally from 0xFFFF to 0x0000.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_reg[gi] <= '0;
      end else if (drain[gi]) begin
        count_reg[gi] <= count_reg[gi] + 16'd1;
      end
    end
  end

  assign a_count = count_reg[0];
  assign b_count = count_reg[1];
`endif

endmodule

// File: tb/tb_dmux16_stream.sv
// ---------------------------------------------------------------------------
// tb_dmux16_stream
//
// Self-checking bench for dmux16_stream (WIDTH=16). The reference model
// treats each output as a FIFO of words. A word is pushed when the input
// handshake completes and popped when the output handshake completes. The
// model also keeps the last word routed to each output. Outputs are sampled
// 1 time unit after the rising edge. Counter checks are compiled only when
// DMUX16_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dmux16_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready = 1'b0;
  logic        b_ready = 1'b0;
`ifdef DMUX16_COUNT_EN
  logic [15:0] a_count, b_count;
`endif

  int compared = 0;
  int mismatched = 0;

  dmux16_stream #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
`ifdef DMUX16_COUNT_EN
    , .a_count(a_count), .b_count(b_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] last_a, last_b;
  int unsigned cnt_a, cnt_b;

  task automatic model_reset();
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    cnt_a = 0; cnt_b = 0;
  endtask

  // A destination accepts a word when it is empty now or when its
  // consumer takes the current word in this cycle.
  function automatic bit model_ready();
    if (in_sel) return (qb.size() == 0) || b_ready;
    else        return (qa.size() == 0) || a_ready;
  endfunction

  // Advances one clock edge and updates the model with the handshakes
  // implied by the inputs seen just before the edge.
  task automatic cycle();
    bit acc, da, db;
    acc = !rst && in_valid && model_ready();
    da  = !rst && (qa.size() > 0) && a_ready;
    db  = !rst && (qb.size() > 0) && b_ready;
    @(posedge clk);
    if (da) begin void'(qa.pop_front()); cnt_a++; end
    if (db) begin void'(qb.pop_front()); cnt_b++; end
    if (acc) begin
      if (in_sel) begin qb.push_back(in_data); last_b = in_data; end
      else        begin qa.push_back(in_data); last_a = in_data; end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h9ABC; in_sel = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    model_reset();
    cycle(); in_sel = 1'b1; cycle();
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL reset_a_valid got %b want 0", a_valid); end
    compared++; if (b_valid !== 1'b0) begin mismatched++; $display("FAIL reset_b_valid got %b want 0", b_valid); end
    compared++; if (a_data !== 16'h0000) begin mismatched++; $display("FAIL reset_a_data got %h want 0000", a_data); end
    compared++; if (b_data !== 16'h0000) begin mismatched++; $display("FAIL reset_b_data got %h want 0000", b_data); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    rst = 1'b0;
    cycle();
    compared++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin mismatched++; $display("FAIL reset_no_transfer got a=%b b=%b want 0 0", a_valid, b_valid); end
    $display("test_reset done");
  endtask

  task automatic test_basic_routing();
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hAAAA;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
    cycle();
    compared++; if (a_valid !== 1'b1 || a_data !== 16'hAAAA) begin mismatched++; $display("FAIL basic_a got v=%b d=%h want 1 aaaa", a_valid, a_data); end
    in_sel = 1'b1; in_data = 16'h5555;
    cycle();
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL basic_a_one_cycle got %b want 0", a_valid); end
    compared++; if (b_valid !== 1'b1 || b_data !== 16'h5555) begin mismatched++; $display("FAIL basic_b got v=%b d=%h want 1 5555", b_valid, b_data); end
    in_valid = 1'b0;
    cycle();
    compared++; if (b_valid !== 1'b0) begin mismatched++; $display("FAIL basic_b_one_cycle got %b want 0", b_valid); end
    $display("test_basic_routing done");
  endtask

  task automatic test_streaming();
    a_ready = 1'b1; b_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 16'(i);
      #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      cycle();
      compared++; if (a_valid !== 1'b1 || a_data !== 16'(i)) begin mismatched++; $display("FAIL stream_a[%0d] got v=%b d=%h want 1 %h", i, a_valid, a_data, 16'(i)); end
      compared++; if (b_valid !== 1'b0) begin mismatched++; $display("FAIL stream_b_idle[%0d] got %b want 0", i, b_valid); end
    end
    in_valid = 1'b0;
    cycle();
    $display("test_streaming done");
  endtask

  task automatic test_independent_stall();
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234;
    cycle();
    in_data = 16'hFFFF;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    cycle();
    compared++; if (a_valid !== 1'b1 || a_data !== 16'h1234) begin mismatched++; $display("FAIL stall_a_hold got v=%b d=%h want 1 1234", a_valid, a_data); end
    in_sel = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stall_other_ready got %b want 1", in_ready); end
    cycle();
    compared++; if (b_valid !== 1'b1 || b_data !== 16'hFFFF) begin mismatched++; $display("FAIL stall_b got v=%b d=%h want 1 ffff", b_valid, b_data); end
    compared++; if (a_data !== 16'h1234) begin mismatched++; $display("FAIL stall_a_untouched got %h want 1234", a_data); end
    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    cycle();
    $display("test_independent_stall done");
  endtask

  task automatic test_replace();
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0F0F;
    cycle();
    a_ready = 1'b1; in_data = 16'hF0F0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL replace_in_ready got %b want 1", in_ready); end
    cycle();
    compared++; if (a_valid !== 1'b1 || a_data !== 16'hF0F0) begin mismatched++; $display("FAIL replace_a got v=%b d=%h want 1 f0f0", a_valid, a_data); end
    in_valid = 1'b0;
    cycle();
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL replace_drain got %b want 0", a_valid); end
    $display("test_replace done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom);
      in_data  = 16'($urandom);
      a_ready  = 1'($urandom_range(0, 2) != 0);
      b_ready  = 1'($urandom_range(0, 3) == 0);
      #1;
      compared++;
      if (in_ready !== model_ready()) begin mismatched++; bad++; $display("FAIL rand_in_ready[%0d] got %b want %b", i, in_ready, model_ready()); end
      cycle();
      compared++;
      if (a_valid !== (qa.size() > 0) || a_data !== last_a) begin
        mismatched++; bad++;
        $display("FAIL rand_a[%0d] got v=%b d=%h want %b %h", i, a_valid, a_data, qa.size() > 0, last_a);
      end
      compared++;
      if (b_valid !== (qb.size() > 0) || b_data !== last_b) begin
        mismatched++; bad++;
        $display("FAIL rand_b[%0d] got v=%b d=%h want %b %h", i, b_valid, b_data, qb.size() > 0, last_b);
      end
`ifdef DMUX16_COUNT_EN
      compared++;
      if (a_count !== 16'(cnt_a) || b_count !== 16'(cnt_b)) begin
        mismatched++; bad++;
        $display("FAIL rand_count[%0d] got %h/%h want %h/%h", i, a_count, b_count, 16'(cnt_a), 16'(cnt_b));
      end
`endif
      if (bad > 20) break;
    end
    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    cycle();
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111; cycle();
    in_sel = 1'b1; in_data = 16'h2222; cycle();
    in_valid = 1'b0;
    // Assert reset between clock edges. The slots must clear before the
    // next edge arrives.
    rst = 1'b1;
    #1;
    compared++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin mismatched++; $display("FAIL async_rst_valid got a=%b b=%b want 0 0", a_valid, b_valid); end
    compared++; if (a_data !== 16'h0000 || b_data !== 16'h0000) begin mismatched++; $display("FAIL async_rst_data got %h/%h want 0000/0000", a_data, b_data); end
    model_reset();
    cycle();
    rst = 1'b0;
    cycle();
    $display("test_async_reset done");
  endtask

`ifdef DMUX16_COUNT_EN
  task automatic test_counters();
    rst = 1'b1; #1; model_reset(); cycle(); rst = 1'b0; cycle();
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      in_data = 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    compared++; if (a_count !== 16'h0001) begin mismatched++; $display("FAIL count_wrap got %h want 0001", a_count); end
    compared++; if (b_count !== 16'h0000) begin mismatched++; $display("FAIL count_b_zero got %h want 0000", b_count); end
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_sel = 1'(i); in_data = 16'(i); cycle();
    end
    rst = 1'b1;
    #1;
    compared++; if (a_count !== 16'h0000 || b_count !== 16'h0000) begin mismatched++; $display("FAIL count_async_rst got %h/%h want 0000/0000", a_count, b_count); end
    model_reset();
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    $display("test_counters done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_routing();
    test_streaming();
    test_independent_stall();
    test_replace();
    test_random();
    test_async_reset();
`ifdef DMUX16_COUNT_EN
    test_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmux16_stream.md
# dmux16_stream

Registered 1-to-2 stream demultiplexer: the routing counterpart of `mux16`. One input stream carries a data word plus a select bit. Each accepted word is steered into a one-entry output slot for port `a` (sel=0) or port `b` (sel=1), with an independent valid/ready handshake per output. It sits between a single producer and two consumers in the datapath.

## Interface
Parameters:
- `WIDTH`, default 16: data word width.

Ports:
- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: asynchronous reset, active-high. Clears all state.
- `in_data`  input  WIDTH: input word.
- `in_sel`  input  1: destination; 0 routes to `a`, 1 routes to `b`.
- `in_valid`  input  1: producer offers `in_data`/`in_sel`.
- `in_ready`  output  1: block accepts this cycle.
- `a_data`  output  WIDTH: slot A word.
- `a_valid`  output  1: slot A holds a word.
- `a_ready`  input  1: consumer A takes the word.
- `b_data`, `b_valid`, `b_ready`: same as the A ports, for slot B.
- `a_count`, `b_count`  output  16: present only with `DMUX16_COUNT_EN` (see Configuration).

## Operation
- Each slot is a register pair {full, data}. `x_valid` = slot full; `x_data` = slot data.
- Input handshake: transfer when `in_valid && in_ready`.
- `in_ready` is combinational: `in_sel ? (!b_valid || b_ready) : (!a_valid || a_ready)`. It depends only on the selected slot.
- Output handshake: slot X drains when `x_valid && x_ready`.
- Per slot, each clock edge:
  - Fill only (input targets X, no drain): full←1, data←`in_data`.
  - Drain only: full←0, data holds.
  - Fill and drain in the same cycle: full stays 1, data←`in_data`. Full throughput is one word per cycle per slot.
  - Neither: hold.
- The non-selected slot is never modified by an input transfer.
- Order is preserved within each output. No ordering relation exists between `a` and `b`.
- While `x_valid && !x_ready`, `x_data` is stable.
- When `in_valid` is 0, `in_sel` and `in_data` are don't-care. `in_ready` may still toggle with `in_sel`.
- Reset values: `a_valid`=0, `b_valid`=0, `a_data`=0, `b_data`=0, counters=0. `in_ready` is therefore 1 during and after reset.
- Reset asserted mid-operation discards slot contents immediately, asynchronously. No handshake completes during reset.

## Timing
- Latency: a word accepted at edge k appears on `x_valid`/`x_data` after edge k. Earliest consumption is at edge k+1.
- Combinational paths: `in_sel`, `a_ready`, `b_ready` → `in_ready`. There is no path from input to output data or valid.
- Back-pressure: a stalled slot blocks only inputs addressed to it. A word for the other slot is accepted in the same cycle.
- Simultaneous events:
  - Fill A while B drains: both occur.
  - Fill and drain of the same slot: replace-in-place, as above.

## Configuration
- Macro `DMUX16_COUNT_EN`.
- Defined:
  - Ports `a_count`/`b_count` exist.
  - Each is a 16-bit counter incremented by 1 on every output handshake of its slot.
  - Counters wrap 0xFFFF→0x0000 and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid`=1 → `a_valid`=`b_valid`=0, `a_data`=`b_data`=0x0000, `in_ready`=1, no transfer recorded.
- **Basic routing:** send 0xAAAA with sel=0, then 0x5555 with sel=1, both consumers ready → `a_data`=0xAAAA one cycle after the first accept, `b_data`=0x5555 one cycle after the second, each valid for exactly 1 cycle.
- **Streaming:** hold `a_ready`=1 and send 0x0001..0x0008 with sel=0 on consecutive cycles → `in_ready` stays 1 and `a` emits 0x0001..0x0008 back-to-back. `b_valid` stays 0 throughout.
- **Independent stall:** `a_ready`=0 with slot A holding 0x1234.
  - Sending sel=0 with 0xFFFF → `in_ready`=0 and `a_data` stays 0x1234.
  - Switching to sel=1 with 0xFFFF → accepted, and `b_data`=0xFFFF next cycle.
- **Full-slot replace:** slot A full with 0x0F0F, `a_ready`=1, and 0xF0F0 offered with sel=0 in the same cycle → 0x0F0F consumed, `a_valid` stays 1, `a_data`=0xF0F0 next cycle.
- **Counters (`DMUX16_COUNT_EN` defined):** force `a_count` to wrap via 65537 A handshakes → `a_count`=0x0001 and `b_count`=0. Asserting `rst` mid-stream → both counters 0 asynchronously.
